// File: rtl/cla_seq_pkg.sv
// Shared types and default sizing for the wide-add sequencer.
// Optional overflow flag is enabled with CLA_SEQ_OVF_EN.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_seq_state_t;

  localparam int CLA_SEQ_NBITS = 16;
  localparam int CLA_SEQ_WORDS = 4;

endpackage

// File: rtl/cla_wide_add_sequencer_cla.sv
// Combinational Nbits-wide carry-lookahead adder slice.
// Generate/propagate terms feed an unrolled carry recurrence.
module CarryLookAheadAdderAlwaysComb #(
  parameter int Nbits = 16
) (
  input  logic [Nbits-1:0] A,
  input  logic [Nbits-1:0] B,
  input  logic             Cin,
  output logic [Nbits-1:0] S,
  output logic             Cout
);

  logic [Nbits-1:0] g;
  logic [Nbits-1:0] p;
  logic [Nbits:0]   c;

  always_comb begin
    g = A & B;
    p = A ^ B;
    c = '0;
    c[0] = Cin;
    for (int i = 0; i < Nbits; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    S    = p ^ c[Nbits-1:0];
    Cout = c[Nbits];
  end

endmodule

// File: rtl/cla_wide_add_sequencer.sv
// Sequences a WORDS*Nbits-bit add over one CLA slice, LSB slice first.
// Define CLA_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module cla_wide_add_sequencer
  import cla_seq_pkg::*;
#(
  parameter int Nbits = CLA_SEQ_NBITS,
  parameter int WORDS = CLA_SEQ_WORDS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORDS*Nbits-1:0] a_in,
  input  logic [WORDS*Nbits-1:0] b_in,
  input  logic                   Cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORDS*Nbits-1:0] sum,
`ifdef CLA_SEQ_OVF_EN
  output logic                   Cout,
  output logic                   ovf
`else
  output logic                   Cout
`endif
);

  localparam int W  = WORDS * Nbits;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  cla_seq_state_t state_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   sum_q;
  logic           carry_q;
  logic           cout_q;
  logic [IW-1:0]  idx_q;

  logic [Nbits-1:0] a_sl;
  logic [Nbits-1:0] b_sl;
  logic [Nbits-1:0] s_sl;
  logic             c_sl;
  logic             last;

  always_comb begin
    a_sl = a_q[32'(idx_q)*Nbits +: Nbits];
    b_sl = b_q[32'(idx_q)*Nbits +: Nbits];
    last = (idx_q == LAST);
  end

  CarryLookAheadAdderAlwaysComb #(
    .Nbits(Nbits)
  ) u_cla (
    .A   (a_sl),
    .B   (b_sl),
    .Cin (carry_q),
    .S   (s_sl),
    .Cout(c_sl)
  );

`ifdef CLA_SEQ_OVF_EN
  logic ovf_q;
  logic msb_cin;

  // Carry into the top bit falls out of a^b^sum at that bit.
  assign msb_cin = a_sl[Nbits-1] ^ b_sl[Nbits-1] ^ s_sl[Nbits-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && last) begin
      ovf_q <= msb_cin ^ c_sl;
    end
  end

  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a_in;
            b_q     <= b_in;
            carry_q <= Cin;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[32'(idx_q)*Nbits +: Nbits] <= s_sl;
          carry_q <= c_sl;
          if (last) begin
            cout_q  <= c_sl;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = !reset && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign Cout      = cout_q;

endmodule

// File: tb/tb_cla_wide_add_sequencer.sv
// Directed-vector bench for cla_wide_add_sequencer at Nbits=16, WORDS=4.
// Overflow checks are active when CLA_SEQ_OVF_EN is defined.
module tb_cla_wide_add_sequencer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic        Cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        Cout;
`ifdef CLA_SEQ_OVF_EN
  logic        ovf;
`endif

  int nvec;
  int nerr;

  cla_wide_add_sequencer #(
    .Nbits(16),
    .WORDS(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .Cin      (Cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
`ifdef CLA_SEQ_OVF_EN
    .Cout     (Cout),
    .ovf      (ovf)
`else
    .Cout     (Cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] obs,
                     input logic [64:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [63:0] a,
                        input logic [63:0] b, input logic ci,
                        input logic [63:0] es, input logic ec,
                        input logic eo);
    int n;
    @(negedge clk);
    a_in = a;
    b_in = b;
    Cin = ci;
    in_valid = 1'b1;
    chk({tag, "_rdy"}, 65'(in_ready), 65'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in = ~a;
    b_in = ~b;
    Cin = ~ci;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 65'(n), 65'(4));
    chk({tag, "_sum"}, 65'(sum), 65'(es));
    chk({tag, "_cout"}, 65'(Cout), 65'(ec));
`ifdef CLA_SEQ_OVF_EN
    chk({tag, "_ovf"}, 65'(ovf), 65'(eo));
`else
    if (eo === 1'bx) $display("unexpected x");
`endif
  endtask

  task automatic retire(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ovld0"}, 65'(out_valid), 65'(1'b0));
    chk({tag, "_irdy1"}, 65'(in_ready), 65'(1'b1));
  endtask

  initial begin
    logic seen;
    logic stable;
    nvec = 0;
    nerr = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_in = '0;
    b_in = '0;
    Cin = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ovld", 65'(out_valid), 65'(1'b0));
    chk("rst_sum", 65'(sum), 65'(0));
    chk("rst_cout", 65'(Cout), 65'(1'b0));
    chk("rst_irdy", 65'(in_ready), 65'(1'b0));
    reset = 1'b0;
    #1;
    chk("rel_irdy", 65'(in_ready), 65'(1'b1));

    run_op("allones", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1,
           64'h0, 1'b1, 1'b0);
    retire("allones");

    run_op("xslice", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
           64'h0000_0000_0001_0000, 1'b0, 1'b0);
    retire("xslice");

    run_op("hold", 64'h0000_0001_0000_0001, 64'h0000_0002_0000_0002,
           1'b0, 64'h0000_0003_0000_0003, 1'b0, 1'b0);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a_in = 64'hDEAD_BEEF_0000_0000 + 64'(i);
      b_in = 64'h1;
      Cin = 1'b1;
      if (sum !== 64'h0000_0003_0000_0003 || Cout !== 1'b0 ||
          out_valid !== 1'b1 || in_ready !== 1'b0)
        stable = 1'b0;
    end
    chk("hold_stable", 65'(stable), 65'(1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    retire("hold");
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("hold_noacc", 65'(seen), 65'(1'b0));

    @(negedge clk);
    a_in = 64'hFFFF_FFFF_FFFF_FFFF;
    b_in = 64'hFFFF_FFFF_FFFF_FFFF;
    Cin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("abort_irdy", 65'(in_ready), 65'(1'b0));
    chk("abort_ovld", 65'(out_valid), 65'(1'b0));
    chk("abort_sum", 65'(sum), 65'(0));
    chk("abort_cout", 65'(Cout), 65'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_nov", 65'(seen), 65'(1'b0));

    run_op("post", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111,
           1'b0, 64'h2345_6789_ABCD_F001, 1'b0, 1'b0);
    retire("post");

    run_op("ovfpos", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
    retire("ovfpos");
    run_op("ovfneg1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
           64'h0, 1'b1, 1'b0);
    retire("ovfneg1");
    run_op("ovfmin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           1'b0, 64'h0, 1'b1, 1'b1);
    retire("ovfmin");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
